dual_port_ram_1clk: RTL and testbench



---
 rtl/dual_port_ram_1clk.sv | 105 ++++++++++
 tb/tb_dual_port_ram_1clk.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_1clk.sv
// Single-clock simple dual-port RAM with a post-reset zero-fill sweep and registered read port.
// Optional macro DPR_WR_BYPASS_EN selects write-first same-address behaviour (default read-first).
module dual_port_ram_1clk #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  init_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  logic [0:0]            r_state;
  logic [0:0]            w_state_next;
  logic [ADDR_WIDTH-1:0] r_sp;
  logic [ADDR_WIDTH-1:0] w_sp_next;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_dout;
  logic [DATA_WIDTH-1:0] w_dout_next;

  logic                  w_in_init;
  logic                  w_sweep_last;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;

  assign w_in_init    = (r_state == ST_INIT);
  assign w_sweep_last = (r_sp == LAST_ADDR);

  always_comb begin
    w_state_next = r_state;
    w_sp_next    = r_sp;
    if (w_in_init) begin
      w_sp_next = r_sp + 1'b1;
      if (w_sweep_last) begin
        w_state_next = ST_READY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_sp    <= '0;
    end else begin
      r_state <= w_state_next;
      r_sp    <= w_sp_next;
    end
  end

  // The sweep owns the write port during INIT; user writes are dropped, not queued.
  always_comb begin
    if (w_in_init) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_sp;
      w_mem_wdata = '0;
    end else begin
      w_mem_we    = we;
      w_mem_addr  = wr_addr;
      w_mem_wdata = din;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we && !rst) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_comb begin
    w_dout_next = r_mem[rd_addr];
`ifdef DPR_WR_BYPASS_EN
    if (we && (wr_addr == rd_addr)) begin
      w_dout_next = din;
    end
`else
`endif
    if (w_in_init) begin
      w_dout_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout <= '0;
    end else begin
      r_dout <= w_dout_next;
    end
  end

  assign dout      = r_dout;
  assign init_done = (r_state == ST_READY);

endmodule

// File: tb/tb_dual_port_ram_1clk.sv
// Directed self-checking bench for dual_port_ram_1clk; honours DPR_WR_BYPASS_EN for the collision case.
module tb_dual_port_ram_1clk;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic [3:0] wr_addr;
  logic [7:0] din;
  logic [3:0] rd_addr;
  logic [7:0] dout;
  logic       init_done;

  int n_checks = 0;
  int n_fail   = 0;

  dual_port_ram_1clk #(
    .ADDR_WIDTH(4),
    .DATA_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .wr_addr  (wr_addr),
    .din      (din),
    .rd_addr  (rd_addr),
    .dout     (dout),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Advance one edge and land 1 time unit after it, clear of the sampling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic exp_done;
    rst = 1'b1; we = 1'b0; wr_addr = '0; din = '0; rd_addr = '0;
    tick(); tick();
    n_checks++;
    if (dout !== 8'h00) begin
      n_fail++; $display("FAIL reset_dout: got %h expected 00", dout);
    end
    n_checks++;
    if (init_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_init_done: got %b expected 0", init_done);
    end
    // User write offered throughout the sweep; must be dropped.
    we = 1'b1; din = 8'h55; wr_addr = 4'd3; rd_addr = 4'd3;
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_done = (k == 16);
      n_checks++;
      if (init_done !== exp_done) begin
        n_fail++;
        $display("FAIL sweep_init_done[%0d]: got %b expected %b", k, init_done, exp_done);
      end
      n_checks++;
      if (dout !== 8'h00) begin
        n_fail++; $display("FAIL sweep_dout[%0d]: got %h expected 00", k, dout);
      end
    end
    we = 1'b0; din = 8'h00; wr_addr = 4'd0;
  endtask

  task automatic test_sweep_zero();
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      tick();
      n_checks++;
      if (dout !== 8'h00) begin
        n_fail++; $display("FAIL sweep_zero[%0d]: got %h expected 00", i, dout);
      end
    end
    n_checks++;
    if (init_done !== 1'b1) begin
      n_fail++; $display("FAIL ready_init_done: got %b expected 1", init_done);
    end
  endtask

  task automatic test_write_during_init();
    rd_addr = 4'd3;
    tick();
    n_checks++;
    if (dout !== 8'h00) begin
      n_fail++; $display("FAIL init_write_dropped: got %h expected 00", dout);
    end
  endtask

  task automatic test_basic_rw();
    we = 1'b1; wr_addr = 4'd1; din = 8'hAA;
    tick();
    wr_addr = 4'd2; din = 8'hBB;
    tick();
    we = 1'b0; rd_addr = 4'd1;
    tick();
    n_checks++;
    if (dout !== 8'hAA) begin
      n_fail++; $display("FAIL basic_read1: got %h expected aa", dout);
    end
    rd_addr = 4'd2;
    tick();
    n_checks++;
    if (dout !== 8'hBB) begin
      n_fail++; $display("FAIL basic_read2: got %h expected bb", dout);
    end
  endtask

  task automatic test_collision();
    logic [7:0] exp_first;
`ifdef DPR_WR_BYPASS_EN
    exp_first = 8'h22;
`else
    exp_first = 8'h11;
`endif
    we = 1'b1; wr_addr = 4'd5; din = 8'h11; rd_addr = 4'd0;
    tick();
    wr_addr = 4'd5; rd_addr = 4'd5; din = 8'h22;
    tick();
    n_checks++;
    if (dout !== exp_first) begin
      n_fail++; $display("FAIL collision_same_edge: got %h expected %h", dout, exp_first);
    end
    we = 1'b0;
    tick();
    n_checks++;
    if (dout !== 8'h22) begin
      n_fail++; $display("FAIL collision_next: got %h expected 22", dout);
    end
  endtask

  task automatic test_independent();
    we = 1'b1; wr_addr = 4'd9; din = 8'h99;
    tick();
    wr_addr = 4'd7; din = 8'h3C; rd_addr = 4'd9;
    tick();
    n_checks++;
    if (dout !== 8'h99) begin
      n_fail++; $display("FAIL indep_read9: got %h expected 99", dout);
    end
    we = 1'b0; rd_addr = 4'd7;
    tick();
    n_checks++;
    if (dout !== 8'h3C) begin
      n_fail++; $display("FAIL indep_read7: got %h expected 3c", dout);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    for (int k = 0; k < 4; k++) begin
      we = 1'b1; wr_addr = 4'(10 + k); din = 8'(8'hC0 + k);
      rd_addr = (k == 0) ? 4'd7 : 4'(10 + k - 1);
      tick();
      exp = (k == 0) ? 8'h3C : 8'(8'hC0 + k - 1);
      n_checks++;
      if (dout !== exp) begin
        n_fail++; $display("FAIL b2b[%0d]: got %h expected %h", k, dout, exp);
      end
    end
    we = 1'b0; rd_addr = 4'd13;
    tick();
    n_checks++;
    if (dout !== 8'hC3) begin
      n_fail++; $display("FAIL b2b_last: got %h expected c3", dout);
    end
  endtask

  task automatic test_reset_mid_op();
    int cycles;
    rd_addr = 4'd1;
    tick();
    n_checks++;
    if (dout !== 8'hAA) begin
      n_fail++; $display("FAIL midrst_pre: got %h expected aa", dout);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (dout !== 8'h00) begin
      n_fail++; $display("FAIL midrst_dout: got %h expected 00", dout);
    end
    n_checks++;
    if (init_done !== 1'b0) begin
      n_fail++; $display("FAIL midrst_init_done: got %b expected 0", init_done);
    end
    tick(); tick();
    rst = 1'b0;
    cycles = 0;
    while (init_done !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
    n_checks++;
    if (cycles !== 16) begin
      n_fail++; $display("FAIL midrst_sweep_len: got %0d expected 16", cycles);
    end
    rd_addr = 4'd1;
    tick();
    n_checks++;
    if (dout !== 8'h00) begin
      n_fail++; $display("FAIL midrst_cleared: got %h expected 00", dout);
    end
  endtask

  initial begin
    test_reset();
    test_sweep_zero();
    test_write_during_init();
    test_basic_rw();
    test_collision();
    test_independent();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
